// File: rtl/counter_modn_cascade_if.sv
// Control/status bundle between a digit driver and one modulo-N counter stage.
interface counter_modn_cascade_if #(
  parameter int unsigned WIDTH = 3
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             pgt;
  logic             tc;
  logic             sat;

  modport master (output en, up, load, load_val, input count, pgt, tc, sat);
  modport slave  (input en, up, load, load_val, output count, pgt, tc, sat);
endinterface

// File: rtl/counter_modn_cascade.sv
// Modulo-N up/down counter stage: parallel load, wrap/saturate, pgt tap, cascade tc.
module counter_modn_cascade #(
  parameter int unsigned MOD    = 7,
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned PGT_AT = 4,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                     clk,
  input  logic                     clear,
  counter_modn_cascade_if.slave    bus
);

  localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] CNT_ZERO = WIDTH'(0);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] PGT_VAL  = WIDTH'(PGT_AT);

  // Reject parameter sets that make the count range or the tap unreachable.
  if (MOD < 2 || (64'(1) << WIDTH) < 64'(MOD) || PGT_AT >= MOD) begin : g_bad_params
    $error("counter_modn_cascade: illegal parameters MOD=%0d WIDTH=%0d PGT_AT=%0d",
           MOD, WIDTH, PGT_AT);
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             pgt_q, pgt_d;
  logic             sat_q, sat_d;
  logic             at_bound;
  logic [WIDTH-1:0] step_val;

  // Next-state: load beats en beats hold; blocked steps only raise sat.
  always_comb begin
    count_d  = count_q;
    pgt_d    = 1'b0;
    sat_d    = sat_q;
    at_bound = bus.up ? (count_q == CNT_MAX) : (count_q == CNT_ZERO);
    if (bus.up) begin
      step_val = at_bound ? CNT_ZERO : (count_q + CNT_ONE);
    end else begin
      step_val = at_bound ? CNT_MAX : (count_q - CNT_ONE);
    end

    if (bus.load) begin
      count_d = (bus.load_val > CNT_MAX) ? CNT_MAX : bus.load_val;
      sat_d   = 1'b0;
    end else if (bus.en) begin
      if (at_bound && !WRAP) begin
        sat_d = 1'b1;
      end else begin
        count_d = step_val;
        pgt_d   = (step_val == PGT_VAL);
        sat_d   = 1'b0;
      end
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      count_q <= CNT_ZERO;
      pgt_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      pgt_q   <= pgt_d;
      sat_q   <= WRAP ? 1'b0 : sat_d;
    end
  end

  assign bus.count = count_q;
  assign bus.pgt   = pgt_q;
  assign bus.sat   = sat_q;
  // Zero-latency terminal count so the next digit steps on the same edge.
  assign bus.tc    = bus.en & (bus.up ? (count_q == CNT_MAX) : (count_q == CNT_ZERO));

endmodule

// File: tb/tb_counter_modn_cascade.sv
// Scoreboard bench: default digit, saturating digit, and a two-digit decade cascade.
module tb_counter_modn_cascade;

  logic clk;
  logic clear;

  counter_modn_cascade_if #(.WIDTH(3)) if0 ();
  counter_modn_cascade_if #(.WIDTH(3)) if1 ();
  counter_modn_cascade_if #(.WIDTH(4)) if2 ();
  counter_modn_cascade_if #(.WIDTH(4)) if3 ();

  counter_modn_cascade #(.MOD(7),  .WIDTH(3), .PGT_AT(4), .WRAP(1'b1)) u_def
    (.clk(clk), .clear(clear), .bus(if0));
  counter_modn_cascade #(.MOD(7),  .WIDTH(3), .PGT_AT(4), .WRAP(1'b0)) u_sat
    (.clk(clk), .clear(clear), .bus(if1));
  counter_modn_cascade #(.MOD(10), .WIDTH(4), .PGT_AT(4), .WRAP(1'b1)) u_lo
    (.clk(clk), .clear(clear), .bus(if2));
  counter_modn_cascade #(.MOD(10), .WIDTH(4), .PGT_AT(4), .WRAP(1'b1)) u_hi
    (.clk(clk), .clear(clear), .bus(if3));

  // Upper digit counts when the lower digit rolls over.
  assign if3.en = if2.tc;

  typedef struct packed {
    logic [3:0] pre_cnt;
    logic       pre_tc;
    logic [3:0] cnt;
    logic       pgt;
    logic       sat;
  } exp_t;
  typedef exp_t [3:0] item_t;

  item_t sb_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model state, per channel.
  int mdl_mod  [4] = '{7, 7, 10, 10};
  int mdl_pgt  [4] = '{4, 4, 4, 4};
  int mdl_wrap [4] = '{1, 0, 1, 1};
  int mdl_c    [4] = '{0, 0, 0, 0};
  int mdl_p    [4] = '{0, 0, 0, 0};
  int mdl_s    [4] = '{0, 0, 0, 0};

  logic [3:0] act_cnt [4];
  logic       act_tc  [4];
  logic       act_pgt [4];
  logic       act_sat [4];

  assign act_cnt[0] = 4'(if0.count);
  assign act_cnt[1] = 4'(if1.count);
  assign act_cnt[2] = if2.count;
  assign act_cnt[3] = if3.count;
  assign act_tc[0]  = if0.tc;
  assign act_tc[1]  = if1.tc;
  assign act_tc[2]  = if2.tc;
  assign act_tc[3]  = if3.tc;
  assign act_pgt[0] = if0.pgt;
  assign act_pgt[1] = if1.pgt;
  assign act_pgt[2] = if2.pgt;
  assign act_pgt[3] = if3.pgt;
  assign act_sat[0] = if0.sat;
  assign act_sat[1] = if1.sat;
  assign act_sat[2] = if2.sat;
  assign act_sat[3] = if3.sat;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int ch, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s ch%0d at %0t: got %0d want %0d", nm, ch, $time, act, exp);
    end
  endtask

  // One modelled edge for a channel, straight from the counting rules.
  task automatic model_edge(input int ch, input bit e, input bit u, input bit ld, input int lv);
    int m;
    int t;
    m = mdl_mod[ch];
    if (ld) begin
      mdl_c[ch] = (lv > m - 1) ? m - 1 : lv;
      mdl_p[ch] = 0;
      mdl_s[ch] = 0;
    end else if (e) begin
      t = u ? mdl_c[ch] + 1 : mdl_c[ch] - 1;
      if (mdl_wrap[ch] != 0) begin
        mdl_c[ch] = (t + m) % m;
        mdl_p[ch] = (mdl_c[ch] == mdl_pgt[ch]) ? 1 : 0;
        mdl_s[ch] = 0;
      end else if (t < 0 || t >= m) begin
        mdl_p[ch] = 0;
        mdl_s[ch] = 1;
      end else begin
        mdl_c[ch] = t;
        mdl_p[ch] = (t == mdl_pgt[ch]) ? 1 : 0;
        mdl_s[ch] = 0;
      end
    end else begin
      mdl_p[ch] = 0;
    end
  endtask

  // Drive one cycle of stimulus and push the expected response.
  task automatic step(input bit cl, input bit e, input bit u, input bit ld,
                      input int lv, input bit hld);
    item_t it;
    bit    en_ch [4];
    int    lv_ch;
    @(negedge clk);
    clear        = cl;
    if0.en       = e;  if0.up = u;  if0.load = ld;  if0.load_val = 3'(lv);
    if1.en       = e;  if1.up = u;  if1.load = ld;  if1.load_val = 3'(lv);
    if2.en       = e;  if2.up = u;  if2.load = ld;  if2.load_val = 4'(lv);
    if3.up       = u;  if3.load = hld;  if3.load_val = 4'(lv);
    #1;
    if (!cl) begin
      for (int ch = 0; ch < 4; ch++) begin
        mdl_c[ch] = 0;
        mdl_p[ch] = 0;
        mdl_s[ch] = 0;
      end
    end
    en_ch[0] = e;
    en_ch[1] = e;
    en_ch[2] = e;
    en_ch[3] = e && (u ? (mdl_c[2] == mdl_mod[2] - 1) : (mdl_c[2] == 0));
    for (int ch = 0; ch < 4; ch++) begin
      it[ch].pre_cnt = 4'(mdl_c[ch]);
      it[ch].pre_tc  = en_ch[ch] && (u ? (mdl_c[ch] == mdl_mod[ch] - 1) : (mdl_c[ch] == 0));
    end
    if (cl) begin
      for (int ch = 0; ch < 4; ch++) begin
        lv_ch = (ch < 2) ? (lv & 7) : (lv & 15);
        model_edge(ch, en_ch[ch], u, (ch == 3) ? hld : ld, lv_ch);
      end
    end
    for (int ch = 0; ch < 4; ch++) begin
      it[ch].cnt = 4'(mdl_c[ch]);
      it[ch].pgt = mdl_p[ch] != 0;
      it[ch].sat = mdl_s[ch] != 0;
    end
    sb_q.push_back(it);
  endtask

  // Monitor: tc and pre-edge count before the edge, registers after it.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        for (int ch = 0; ch < 4; ch++) begin
          chk("pre_count", ch, int'(act_cnt[ch]), int'(it[ch].pre_cnt));
          chk("tc", ch, int'(act_tc[ch]), int'(it[ch].pre_tc));
        end
        @(posedge clk);
        #1;
        for (int ch = 0; ch < 4; ch++) begin
          chk("count", ch, int'(act_cnt[ch]), int'(it[ch].cnt));
          chk("pgt", ch, int'(act_pgt[ch]), int'(it[ch].pgt));
          chk("sat", ch, int'(act_sat[ch]), int'(it[ch].sat));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b0;
    if0.en = 1'b0; if0.up = 1'b0; if0.load = 1'b0; if0.load_val = '0;
    if1.en = 1'b0; if1.up = 1'b0; if1.load = 1'b0; if1.load_val = '0;
    if2.en = 1'b0; if2.up = 1'b0; if2.load = 1'b0; if2.load_val = '0;
    if3.up = 1'b0; if3.load = 1'b0; if3.load_val = '0;

    // Async reset mid-operation, held over edges with en high.
    step(1, 0, 0, 1, 5, 1);
    step(1, 1, 1, 0, 0, 0);
    repeat (3) step(0, 1, 1, 0, 0, 0);

    // Wrap up / saturate up, then one step down off the boundary.
    step(1, 0, 1, 1, 0, 1);
    repeat (9) step(1, 1, 1, 0, 0, 0);
    step(1, 0, 1, 1, 0, 1);
    repeat (8) step(1, 1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);

    // Down wrap, then idle on the tap value.
    step(1, 0, 0, 1, 0, 1);
    repeat (3) step(1, 1, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0);

    // Load priority over en, clamping, and no pgt on a load of the tap value.
    step(1, 1, 1, 1, 3, 1);
    step(1, 1, 1, 1, 7, 1);
    step(1, 1, 1, 1, 15, 1);
    step(1, 1, 1, 1, 4, 1);
    step(1, 0, 1, 0, 0, 0);

    // Two-digit decade cascade over a full 100-step period.
    step(1, 0, 1, 1, 0, 1);
    repeat (100) step(1, 1, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0, 1);
    repeat (25) step(1, 1, 0, 0, 0, 0);

    // Random traffic, including occasional clears.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
           ($urandom_range(0, 15) == 0));
    end

    @(posedge clk);
    #3;
    chk("drain", 0, sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_modn_cascade.md
Name: counter_modn_cascade

Overview:
Parametrised modulo-N up/down counter with a programmable single-cycle pulse tap, parallel load, and wrap or saturate mode. It is the generalised successor to the fixed mod-7 encoder counter: one instance per timer digit or encoder stage. Instances chain through a combinational terminal-count output (tc) to build multi-digit timers.

Parameters:
MOD, 7, modulus; count range 0..MOD-1; legal MOD >= 2
WIDTH, 3, count width; must satisfy 2^WIDTH >= MOD
PGT_AT, 4, count value that fires pgt; legal 0 <= PGT_AT < MOD
WRAP, 1, 1 = wrap at boundaries; 0 = saturate at boundaries

Ports:
clk  input  1  clock; all state updates on the rising edge
clear  input  1  reset, asynchronous, active-low
en  input  1  count enable; one step per rising edge while high
up  input  1  direction: 1 = increment, 0 = decrement
load  input  1  synchronous parallel load; has priority over en
load_val  input  WIDTH  load value; clamped to MOD-1
count  output  WIDTH  current count, registered
pgt  output  1  registered one-cycle pulse when a step lands on PGT_AT
tc  output  1  combinational terminal count, for cascading
sat  output  1  registered flag: a step was blocked at a boundary (WRAP=0 only)

Behaviour:
- Reset (clear low): immediately and asynchronously, independent of clk, drives count=0, pgt=0, sat=0.
  - Holds these values while clear is low.
  - Mid-operation reset discards any step in progress.
  - The first rising edge after clear rises is processed normally.
- Per-edge priority: load > en > hold.
- Load (load=1):
  - count <= min(load_val, MOD-1).
  - pgt <= 0; a load never fires pgt, even when the loaded value equals PGT_AT.
  - sat <= 0. en is ignored this cycle.
- Step up (en=1, up=1, load=0):
  - count < MOD-1: count+1.
  - count == MOD-1, WRAP=1: count <= 0.
  - count == MOD-1, WRAP=0: count holds and sat <= 1.
- Step down (en=1, up=0, load=0):
  - count > 0: count-1.
  - count == 0, WRAP=1: count <= MOD-1.
  - count == 0, WRAP=0: count holds and sat <= 1.
- sat:
  - Cleared by load, or by any step that changes count.
  - Held when en=0.
  - Tied to 0 when WRAP=1.
- pgt:
  - Set to 1 at an edge where a step (not load, not a blocked hold) changes count to PGT_AT.
  - Otherwise 0 at every edge.
  - Consequently pgt is high for exactly one cycle per entry into PGT_AT, even if en drops and count stays at PGT_AT.
  - Both up and down steps can fire it.
- tc = en & (up ? count==MOD-1 : count==0), purely combinational with no register.
  - Asserts in saturate mode as well.
  - Feed tc into the en of the next digit; both digits share clk and clear.
- Arithmetic: all compares and steps are done in WIDTH bits. Values in MOD..2^WIDTH-1 are unreachable, because load clamps.
- Parameter checks: illegal parameter combinations produce a simulation-time $error at time 0. Synthesis behaviour for illegal parameters is undefined.
- Latency: count, pgt and sat update 1 edge after their inputs are sampled; tc has zero latency.

Test Plan:
1. Async reset, defaults: count to 5, drop clear between edges -> count=0, pgt=0, sat=0 before the next edge; hold clear low 3 edges with en=1 -> count stays 0.
2. Wrap up, defaults: en=1, up=1, 9 edges from 0 -> count 1,2,3,4,5,6,0,1,2; pgt=1 only in the cycle count=4; tc=1 only while count=6.
3. Saturate, WRAP=0: up 8 edges from 0 -> count held at 6, sat=1 from edge 7; then up=0 one edge -> count=5, sat=0; pgt pulsed once (at 4).
4. Down wrap, defaults: count 0, en=1, up=0 -> 6, then 5, then 4 with pgt=1 for one cycle; en=0 for 3 edges at 4 -> pgt=0, count=4.
5. Load priority: load=1, en=1, load_val=3 -> count=3; load_val=7 -> count=6 (clamped); load_val=4 -> count=4, pgt=0.
6. Cascade, two instances MOD=10, WIDTH=4, upper en = lower tc: 10 up steps -> upper=1, lower=0; 100 steps -> both 0; upper pgt fires once when upper reaches PGT_AT.
